pgm_ddram_arbiter: RTL and testbench
====================================

// Module: pgm_ddram_arbiter
// PURPOSE
// N-channel DDRAM read arbiter, parametrised successor of the fixed CPU/video/audio SDRAM mux in the PGM core.
// Grants one requester at a time, issues a single 64-bit DDRAM read and returns the captured word with a 1-cycle ack.
// Supports fixed-priority or round-robin mode, a loader write passthrough, and a completion watchdog.
// Sits in the 50 MHz memory domain; requesters are synchronised to clk before reaching it.
// PARAMETERS
// NCH      4    number of read channels (2..8)
// AW       29   DDRAM word address width
// RR_MODE  1    0 = fixed priority (channel 0 highest), 1 = round robin
// TIMEOUT  255  max cycles in WAIT before forced completion (8-bit counter, 1..255)
// PORTS
// clk               in   1       memory clock; all logic on posedge
// reset_n           in   1       asynchronous active-low reset
// req               in   NCH     per-channel read request, level, held until ack
// addr              in   NCH*AW  per-channel address, channel i at [i*AW +: AW], stable while req
// ack               out  NCH     one-hot 1-cycle pulse: rdata valid for that channel
// rdata             out  64      last captured DDRAM word, held until next completion
// gnt_id            out  3       index of channel currently or last granted
// load_en           in   1       loader active: arbiter enters passthrough
// load_we           in   1       loader write strobe
// load_addr         in   AW      loader word address
// load_din          in   64      loader write data
// load_be           in   8       loader byte enables
// ddram_rd          out  1       read strobe
// ddram_we          out  1       write strobe (loader only)
// ddram_addr        out  AW      DDRAM address
// ddram_din         out  64      write data
// ddram_be          out  8       byte enables (8'hFF on reads)
// ddram_busy        in   1       controller cannot accept a command this cycle
// ddram_dout        in   64      read data
// ddram_dout_ready  in   1       read data valid
// timeout_err       out  1       sticky: a WAIT timed out
// BEHAVIOUR
// - Reset: state=IDLE, ack=0, rdata=0, gnt_id=0, ddram_rd=0, ddram_we=0, timeout_err=0, RR pointer=NCH-1.
// - States: IDLE, ISSUE, WAIT, ACK, LOAD.
// - IDLE: load_en -> LOAD (beats any req). Else if any req: choose winner, latch addr and gnt_id, -> ISSUE.
// - Fixed mode: lowest asserted index wins. RR mode: first asserted index after RR pointer, modulo NCH;
//   pointer updates to the winner on grant.
// - ISSUE: ddram_rd=1, ddram_addr=latched addr, ddram_be=8'hFF. Held while ddram_busy=1.
//   First cycle with busy=0 is the accept -> WAIT; ddram_rd low from the next cycle.
// - WAIT: on ddram_dout_ready, rdata<=ddram_dout, -> ACK. Counter counts WAIT cycles.
//   At TIMEOUT: rdata<=64'hFFFF_FFFF_FFFF_FFFF, timeout_err<=1, -> ACK.
// - ACK: ack[gnt_id]=1 for exactly this cycle -> IDLE. A req still high in IDLE right after ACK is a new request.
// - Latency: req rises at cycle 0 with busy=0 -> rd at cycle 1 -> WAIT at cycle 2.
//   dout_ready at cycle k -> ack at cycle k+1.
// - LOAD: ddram_we=load_we, ddram_addr=load_addr, ddram_din=load_din, ddram_be=load_be (combinational), ddram_rd=0.
//   req ignored. load_en low -> IDLE.
// - load_en asserted mid-transaction: the current ISSUE/WAIT/ACK completes normally, then LOAD; no read is aborted.
// - ddram_dout_ready outside WAIT is ignored: no capture, no ack.
// - req dropped before ack: the transaction still completes and ack still pulses; a requester never sees a lost ack.
// - Outside LOAD: ddram_we=0, ddram_din=0. Outside ISSUE/LOAD: ddram_addr holds the last latched address.
// - Async reset mid-transaction: immediate return to reset values; the outstanding DDRAM read is abandoned.
// - timeout_err clears only on reset.
// TESTING
// - Single req[2], addr=29'h100, busy=0, dout_ready after 5 cycles with data 64'h0123_4567_89AB_CDEF
//   -> rd for 1 cycle at addr 29'h100, then ack=4'b0100 one cycle with that rdata.
// - RR_MODE=1, req=4'b1111 held, each ack followed by req reasserted -> grant order 0,1,2,3,0.
//   RR_MODE=0 same stimulus -> channel 0 granted every time.
// - busy=1 for 10 cycles during ISSUE -> rd and addr held all 10 cycles; WAIT entered only on the first busy=0 cycle.
// - No dout_ready after grant with TIMEOUT=16 -> ack after 16 WAIT cycles, rdata all ones, timeout_err=1 until reset.
// - load_en rises during WAIT -> read completes and acks, then LOAD passthrough: load_we/load_addr=29'h20 appear
//   on ddram_we/ddram_addr, ddram_rd=0, pending req ignored until load_en falls.
// - reset_n low during WAIT -> outputs return to reset values immediately; stray dout_ready after release -> no ack.

Source files
------------

// File: rtl/pgm_ddram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | pgm_ddram_arbiter: N-channel DDRAM read arbiter with loader passthrough  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pgm_ddram_arbiter #(
  parameter int NCH     = 4,
  parameter int AW      = 29,
  parameter int RR_MODE = 1,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NCH-1:0]    req,
  input  logic [NCH*AW-1:0] addr,
  output logic [NCH-1:0]    ack,
  output logic [63:0]       rdata,
  output logic [2:0]        gnt_id,
  input  logic              load_en,
  input  logic              load_we,
  input  logic [AW-1:0]     load_addr,
  input  logic [63:0]       load_din,
  input  logic [7:0]        load_be,
  output logic              ddram_rd,
  output logic              ddram_we,
  output logic [AW-1:0]     ddram_addr,
  output logic [63:0]       ddram_din,
  output logic [7:0]        ddram_be,
  input  logic              ddram_busy,
  input  logic [63:0]       ddram_dout,
  input  logic              ddram_dout_ready,
  output logic              timeout_err
);

  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_issue = 3'd1;
  localparam logic [2:0] c_st_wait  = 3'd2;
  localparam logic [2:0] c_st_ack   = 3'd3;
  localparam logic [2:0] c_st_load  = 3'd4;
  localparam logic [7:0] c_tmo_last = 8'(TIMEOUT - 1);

  logic [2:0]    r_state;
  logic [2:0]    w_next_state;
  logic [AW-1:0] r_addr;
  logic [2:0]    r_gnt_id;
  logic [2:0]    r_ptr;
  logic [63:0]   r_rdata;
  logic [7:0]    r_cnt;
  logic          r_timeout_err;
  logic [2:0]    w_winner;
  logic          w_found;
  logic [AW-1:0] w_sel_addr;
  logic          w_any_req;
  logic          w_tmo;
  logic          w_grant;

  function automatic int f_wrap(input int v);
    return (v >= NCH) ? v - NCH : v;
  endfunction

  assign w_any_req = |req;
  assign w_tmo     = (r_cnt == c_tmo_last);
  assign w_grant   = (r_state == c_st_idle) && !load_en && w_any_req;

  // Round robin searches from the channel after the last winner, wrapping at NCH.
  always_comb begin
    w_winner   = '0;
    w_found    = 1'b0;
    w_sel_addr = '0;
    if (RR_MODE != 0) begin
      for (int k = 1; k <= NCH; k++) begin
        for (int c = 0; c < NCH; c++) begin
          if (!w_found && req[c] && (3'(c) == 3'(f_wrap(int'(r_ptr) + k)))) begin
            w_found  = 1'b1;
            w_winner = 3'(c);
          end
        end
      end
    end else begin
      for (int k = NCH - 1; k >= 0; k--) begin
        if (req[k]) w_winner = 3'(k);
      end
    end
    for (int k = 0; k < NCH; k++) begin
      if (w_winner == 3'(k)) w_sel_addr = addr[k*AW +: AW];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= c_st_idle;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle:  if (load_en) w_next_state = c_st_load;
                  else if (w_any_req) w_next_state = c_st_issue;
      c_st_issue: if (!ddram_busy) w_next_state = c_st_wait;
      c_st_wait:  if (ddram_dout_ready || w_tmo) w_next_state = c_st_ack;
      c_st_ack:   w_next_state = c_st_idle;
      c_st_load:  if (!load_en) w_next_state = c_st_idle;
      default:    w_next_state = c_st_idle;
    endcase
  end

  always_comb begin
    ddram_rd   = (r_state == c_st_issue);
    ddram_we   = 1'b0;
    ddram_addr = r_addr;
    ddram_din  = '0;
    ddram_be   = 8'hFF;
    if (r_state == c_st_load) begin
      ddram_we   = load_we;
      ddram_addr = load_addr;
      ddram_din  = load_din;
      ddram_be   = load_be;
    end
    for (int i = 0; i < NCH; i++) begin
      ack[i] = (r_state == c_st_ack) && (r_gnt_id == 3'(i));
    end
  end

  // Data return path; a dout_ready on the final WAIT cycle wins over the watchdog.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr        <= '0;
      r_gnt_id      <= '0;
      r_ptr         <= 3'(NCH - 1);
      r_rdata       <= '0;
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_grant) begin
        r_addr   <= w_sel_addr;
        r_gnt_id <= w_winner;
        r_ptr    <= w_winner;
      end
      if (r_state == c_st_wait) begin
        r_cnt <= r_cnt + 8'd1;
        if (ddram_dout_ready) begin
          r_rdata <= ddram_dout;
        end else if (w_tmo) begin
          r_rdata       <= '1;
          r_timeout_err <= 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign rdata       = r_rdata;
  assign gnt_id      = r_gnt_id;
  assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_pgm_ddram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pgm_ddram_arbiter: round-robin and fixed-priority arbiters side by side|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_pgm_ddram_arbiter;
  localparam int NCH = 4;
  localparam int AW  = 29;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic [NCH-1:0]    req;
  logic [NCH*AW-1:0] addr;
  logic              load_en, load_we;
  logic [AW-1:0]     load_addr;
  logic [63:0]       load_din;
  logic [7:0]        load_be;
  logic              busy, ready;
  logic [63:0]       dout;

  logic [NCH-1:0] a_ack, b_ack;
  logic [63:0]    a_rdata, b_rdata, a_din, b_din;
  logic [2:0]     a_gnt, b_gnt;
  logic           a_rd, b_rd, a_we, b_we, a_terr, b_terr;
  logic [AW-1:0]  a_addr, b_addr;
  logic [7:0]     a_be, b_be;

  pgm_ddram_arbiter #(.NCH(NCH), .AW(AW), .RR_MODE(1), .TIMEOUT(16)) u_rr (
    .clk(clk), .reset_n(reset_n), .req(req), .addr(addr), .ack(a_ack), .rdata(a_rdata),
    .gnt_id(a_gnt), .load_en(load_en), .load_we(load_we), .load_addr(load_addr),
    .load_din(load_din), .load_be(load_be), .ddram_rd(a_rd), .ddram_we(a_we),
    .ddram_addr(a_addr), .ddram_din(a_din), .ddram_be(a_be), .ddram_busy(busy),
    .ddram_dout(dout), .ddram_dout_ready(ready), .timeout_err(a_terr));

  pgm_ddram_arbiter #(.NCH(NCH), .AW(AW), .RR_MODE(0), .TIMEOUT(16)) u_fx (
    .clk(clk), .reset_n(reset_n), .req(req), .addr(addr), .ack(b_ack), .rdata(b_rdata),
    .gnt_id(b_gnt), .load_en(load_en), .load_we(load_we), .load_addr(load_addr),
    .load_din(load_din), .load_be(load_be), .ddram_rd(b_rd), .ddram_we(b_we),
    .ddram_addr(b_addr), .ddram_din(b_din), .ddram_be(b_be), .ddram_busy(busy),
    .ddram_dout(dout), .ddram_dout_ready(ready), .timeout_err(b_terr));

  typedef struct {
    logic [3:0] req;
    logic [2:0] rr;
    logic [2:0] fx;
  } vec_t;

  vec_t vecs[10];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] cha(input logic [2:0] i);
    logic [NCH*AW-1:0] v;
    v = addr;
    return v[int'(i)*AW +: AW];
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Hand-derived grant sequence; RR pointer starts at 3.
    vecs[0] = '{4'b1111, 3'd0, 3'd0};
    vecs[1] = '{4'b1111, 3'd1, 3'd0};
    vecs[2] = '{4'b1111, 3'd2, 3'd0};
    vecs[3] = '{4'b1111, 3'd3, 3'd0};
    vecs[4] = '{4'b1111, 3'd0, 3'd0};
    vecs[5] = '{4'b1010, 3'd1, 3'd1};
    vecs[6] = '{4'b1001, 3'd3, 3'd0};
    vecs[7] = '{4'b0110, 3'd1, 3'd1};
    vecs[8] = '{4'b0010, 3'd1, 3'd1};
    vecs[9] = '{4'b1000, 3'd3, 3'd3};

    reset_n = 1'b0; req = '0; load_en = 1'b0; load_we = 1'b0; load_addr = '0;
    load_din = '0; load_be = '0; busy = 1'b0; ready = 1'b0; dout = '0;
    addr = {29'h1300, 29'h100, 29'h1100, 29'h1000};
    tick; tick;
    chk("rst_ack", 64'(a_ack | b_ack), 64'd0);
    chk("rst_rdata", a_rdata, 64'd0);
    chk("rst_gnt", 64'(a_gnt), 64'd0);
    chk("rst_rd", 64'(a_rd | b_rd), 64'd0);
    chk("rst_we", 64'(a_we), 64'd0);
    chk("rst_terr", 64'(a_terr), 64'd0);
    reset_n = 1'b1;
    tick;

    for (int i = 0; i < 10; i++) begin
      req = vecs[i].req;
      tick;
      chk("gnt_rr", 64'(a_gnt), 64'(vecs[i].rr));
      chk("gnt_fx", 64'(b_gnt), 64'(vecs[i].fx));
      chk("rd_issue", 64'(a_rd), 64'd1);
      chk("addr_rr", 64'(a_addr), 64'(cha(vecs[i].rr)));
      tick;
      ready = 1'b1;
      dout = {32'hA5A5_0000, 32'(i)};
      tick;
      ready = 1'b0;
      chk("ack_rr", 64'(a_ack), 64'(4'b0001 << vecs[i].rr));
      chk("ack_fx", 64'(b_ack), 64'(4'b0001 << vecs[i].fx));
      chk("rdata_rr", a_rdata, {32'hA5A5_0000, 32'(i)});
      tick;
      chk("ack_clr", 64'(a_ack | b_ack), 64'd0);
    end
    req = '0;
    tick;

    // Single request on channel 2, data five WAIT cycles later.
    req = 4'b0100;
    tick;
    chk("s_rd", 64'(a_rd), 64'd1);
    chk("s_addr", 64'(a_addr), 64'(29'h100));
    chk("s_be", 64'(a_be), 64'hFF);
    chk("s_gnt", 64'(a_gnt), 64'd2);
    tick;
    chk("s_rd_low", 64'(a_rd), 64'd0);
    for (int j = 0; j < 4; j++) begin
      chk("s_no_ack", 64'(a_ack), 64'd0);
      tick;
    end
    ready = 1'b1;
    dout = 64'h0123_4567_89AB_CDEF;
    tick;
    ready = 1'b0;
    chk("s_ack", 64'(a_ack), 64'(4'b0100));
    chk("s_rdata", a_rdata, 64'h0123_4567_89AB_CDEF);
    req = '0;
    tick;
    chk("s_ack_once", 64'(a_ack), 64'd0);
    chk("s_rdata_hold", a_rdata, 64'h0123_4567_89AB_CDEF);

    // Controller busy for ten ISSUE cycles.
    req = 4'b0010;
    busy = 1'b1;
    tick;
    for (int j = 0; j < 10; j++) begin
      chk("b_rd_held", 64'(a_rd), 64'd1);
      chk("b_addr_held", 64'(a_addr), 64'(29'h1100));
      tick;
    end
    busy = 1'b0;
    chk("b_rd_accept", 64'(a_rd), 64'd1);
    tick;
    chk("b_rd_low", 64'(a_rd), 64'd0);
    ready = 1'b1;
    dout = 64'h77;
    tick;
    ready = 1'b0;
    chk("b_ack", 64'(a_ack), 64'(4'b0010));
    req = '0;
    tick;

    // No data: watchdog fires after 16 WAIT cycles.
    req = 4'b1000;
    tick;
    tick;
    for (int j = 1; j < 16; j++) begin
      chk("t_no_ack", 64'(a_ack), 64'd0);
      tick;
    end
    chk("t_no_ack_last", 64'(a_ack), 64'd0);
    chk("t_terr_early", 64'(a_terr), 64'd0);
    tick;
    chk("t_ack", 64'(a_ack), 64'(4'b1000));
    chk("t_rdata", a_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t_terr", 64'(a_terr), 64'd1);
    chk("t_terr_fx", 64'(b_terr), 64'd1);
    req = '0;
    tick;
    chk("t_terr_sticky", 64'(a_terr), 64'd1);

    // Loader asserts while a read is outstanding.
    req = 4'b0001;
    tick;
    tick;
    load_en = 1'b1; load_we = 1'b1; load_addr = 29'h20;
    load_din = 64'hDEAD_BEEF_CAFE_F00D; load_be = 8'h0F;
    tick;
    chk("l_we_wait", 64'(a_we), 64'd0);
    chk("l_din_wait", a_din, 64'd0);
    ready = 1'b1;
    dout = 64'h1111;
    tick;
    ready = 1'b0;
    chk("l_ack", 64'(a_ack), 64'(4'b0001));
    chk("l_rdata", a_rdata, 64'h1111);
    tick;
    chk("l_we_idle", 64'(a_we), 64'd0);
    tick;
    chk("l_we", 64'(a_we), 64'd1);
    chk("l_addr", 64'(a_addr), 64'(29'h20));
    chk("l_din", a_din, 64'hDEAD_BEEF_CAFE_F00D);
    chk("l_be", 64'(a_be), 64'h0F);
    for (int j = 0; j < 3; j++) begin
      tick;
      chk("l_rd_off", 64'(a_rd | b_rd), 64'd0);
      chk("l_ack_off", 64'(a_ack), 64'd0);
    end
    load_we = 1'b0;
    #1;
    chk("l_we_pass", 64'(a_we), 64'd0);
    load_en = 1'b0;
    tick;
    chk("l_we_exit", 64'(a_we), 64'd0);
    chk("l_addr_hold", 64'(a_addr), 64'(29'h1000));
    tick;
    chk("l_pending_rd", 64'(a_rd), 64'd1);
    tick;
    ready = 1'b1;
    tick;
    ready = 1'b0;
    req = '0;
    tick;

    // Async reset during WAIT, then a stray dout_ready.
    req = 4'b0100;
    tick;
    tick;
    reset_n = 1'b0;
    #1;
    chk("r_ack", 64'(a_ack), 64'd0);
    chk("r_rdata", a_rdata, 64'd0);
    chk("r_gnt", 64'(a_gnt), 64'd0);
    chk("r_rd", 64'(a_rd), 64'd0);
    chk("r_terr", 64'(a_terr | b_terr), 64'd0);
    req = '0;
    tick;
    reset_n = 1'b1;
    tick;
    ready = 1'b1;
    dout = 64'h5555;
    tick;
    tick;
    chk("r_stray_ack", 64'(a_ack | b_ack), 64'd0);
    chk("r_stray_rdata", a_rdata, 64'd0);
    chk("r_stray_rd", 64'(a_rd), 64'd0);
    ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
